// File: rtl/frame_sequencer_if.sv
// Sample path between the framer, the frame sequencer and the FFT engine.
// The master side is the sequencer: it accepts samples on s_* and presents
// framed samples on m_*. The slave side is the surrounding framer/FFT pair.
interface frame_sequencer_if #(
  parameter int WIDTH = 16,
  parameter int AW    = 9
);
  // upstream sample stream
  logic [WIDTH-1:0] s_data;
  logic             s_valid;
  logic             s_ready;

  // framed stream towards the FFT
  logic [WIDTH-1:0] m_data;
  logic             m_valid;
  logic             m_ready;
  logic             m_first;
  logic             m_last;
  logic [AW-1:0]    win_addr;

  modport master (
    input  s_data, s_valid, m_ready,
    output s_ready, m_data, m_valid, m_first, m_last, win_addr
  );

  modport slave (
    output s_data, s_valid, m_ready,
    input  s_ready, m_data, m_valid, m_first, m_last, win_addr
  );
endinterface

// File: rtl/frame_sequencer.sv
// Frame sequencer: cuts the framer's sample stream into FRAME_LEN-sample
// frames (first/last flags plus window-ROM index) and holds the next frame
// until the FFT reports completion of the current one. One frame in flight.
module frame_sequencer #(
  parameter int FRAME_LEN = 512,
  parameter int WIDTH     = 16,
  parameter int AW        = $clog2(FRAME_LEN)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              fft_done,
  frame_sequencer_if.master bus,
  output logic              busy,
  output logic [15:0]       frame_count,
  output logic              err
);

  localparam logic [AW-1:0] LAST_IDX = AW'(FRAME_LEN - 1);

  typedef enum logic [1:0] {IDLE, STREAM, WAIT_DONE} state_t;

  state_t           state;
  logic [AW-1:0]    idx;
  logic             done_pend;

  logic [WIDTH-1:0] m_data;
  logic             m_valid;
  logic             m_first;
  logic             m_last;
  logic [AW-1:0]    win_addr;

  logic             s_ready;
  logic             accept;
  logic             done_seen;

  // Single output register, no skid: take a new sample only when the slot is
  // empty or being drained this cycle. No dependency on s_valid.
  always_comb begin
    s_ready   = (state == STREAM) && (!m_valid || bus.m_ready);
    accept    = s_ready && bus.s_valid;
    done_seen = fft_done || done_pend;
  end

  assign bus.s_ready  = s_ready;
  assign bus.m_data   = m_data;
  assign bus.m_valid  = m_valid;
  assign bus.m_first  = m_first;
  assign bus.m_last   = m_last;
  assign bus.win_addr = win_addr;

  // busy decodes the state register only, so it cannot glitch
  assign busy = (state != IDLE);

  // Sequencing FSM together with the output register, frame counter and error flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= '0;
      done_pend   <= 1'b0;
      m_data      <= '0;
      m_valid     <= 1'b0;
      m_first     <= 1'b0;
      m_last      <= 1'b0;
      win_addr    <= '0;
      frame_count <= '0;
      err         <= 1'b0;
    end else begin
      // Output register: load on accept, otherwise drop valid once taken.
      // Data and side-band fields keep their last value when not reloaded.
      if (accept) begin
        m_data   <= bus.s_data;
        win_addr <= idx;
        m_first  <= (idx == '0);
        m_last   <= (idx == LAST_IDX);
        m_valid  <= 1'b1;
      end else if (m_valid && bus.m_ready) begin
        m_valid  <= 1'b0;
      end

      case (state)
        IDLE: begin
          // a completion with no frame outstanding is a protocol error
          if (fft_done) err <= 1'b1;
          if (enable) begin
            state <= STREAM;
            idx   <= '0;
          end
        end

        STREAM: begin
          // enable is deliberately not looked at here: frames are never cut short
          if (fft_done) err <= 1'b1;
          if (accept) begin
            if (idx == LAST_IDX) begin
              state <= WAIT_DONE;
              idx   <= '0;
            end else begin
              idx <= idx + AW'(1);
            end
          end
        end

        WAIT_DONE: begin
          if (done_seen && !m_valid) begin
            frame_count <= frame_count + 16'd1;
            done_pend   <= 1'b0;
            state       <= enable ? STREAM : IDLE;
          end else if (fft_done) begin
            // FFT claims completion while the last sample still sits in the
            // output register: remember it, finish once the register drains
            done_pend <= 1'b1;
            err       <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/frame_sequencer.md
# frame_sequencer

Frame controller between the pre-emphasis/framing stage and the FFT engine of the audio-spectrum path. Accepts the framer's 16-bit sample stream, delimits it into fixed-length frames (first/last markers plus window-ROM index), and holds the next frame off until the FFT signals completion of the current one. One frame in flight at a time; backpressure propagates upstream.

## Interface
- FRAME_LEN, 512, samples per frame; power of two, 4..1024.
- WIDTH, 16, sample width.
- AW, $clog2(FRAME_LEN), window address / sample index width.
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high; one clock domain, async assert.
- enable  in  1  level; allows new frames to start.
- s_data  in  WIDTH  upstream sample (signed).
- s_valid  in  1  upstream sample valid.
- s_ready  out  1  sample accepted when s_valid & s_ready.
- m_data  out  WIDTH  registered sample to FFT.
- m_valid  out  1  m_data valid.
- m_ready  in  1  FFT accepts when m_valid & m_ready.
- m_first  out  1  qualifies m_data as sample 0 of a frame.
- m_last  out  1  qualifies m_data as sample FRAME_LEN-1.
- win_addr  out  AW  window-coefficient index aligned with m_data.
- fft_done  in  1  one-cycle pulse, FFT finished current frame.
- busy  out  1  high in STREAM or WAIT_DONE.
- frame_count  out  16  completed frames (fft_done accepted), wraps 0xFFFF->0.
- err  out  1  sticky protocol error flag.

## Operation
- FSM states IDLE, STREAM, WAIT_DONE.
- IDLE: s_ready=0. enable=1 -> STREAM next cycle, sample index idx<=0.
- STREAM: s_ready = !m_valid | m_ready (one-entry output register, no skid buffer). On accept: m_data<=s_data, win_addr<=idx, m_first<=(idx==0), m_last<=(idx==FRAME_LEN-1), m_valid<=1, idx<=idx+1. On accepting idx==FRAME_LEN-1 -> WAIT_DONE, idx<=0.
- Output register: if m_valid & m_ready and no new accept, m_valid<=0; m_data/win_addr/flags hold last value.
- WAIT_DONE: s_ready=0. Frame completes when fft_done seen (pulse this cycle or latched done_pend) and m_valid==0: frame_count+=1, done_pend<=0; next state STREAM if enable else IDLE.
- fft_done arriving in WAIT_DONE while m_valid==1 (last sample not yet taken): latch done_pend, err<=1 (done before last sample consumed).
- fft_done in IDLE or STREAM: ignored for sequencing, err<=1.
- enable deasserted mid-frame: current frame completes in full (no truncation); no new frame starts.
- Frames never partial: idx only resets on last-sample accept or reset.
- err cleared only by reset.

## Timing
- Reset values: s_ready=0, m_valid=0, m_data=0, m_first=0, m_last=0, win_addr=0, busy=0, frame_count=0, err=0, state IDLE, idx=0, done_pend=0.
- Reset mid-frame: all state to reset values immediately; partially delivered frame abandoned; bench must not expect completion.
- enable 0->1 in IDLE: s_ready high 1 cycle later.
- Latency s_data accept -> m_valid: 1 cycle. Full throughput (1 sample/cycle) while m_ready=1.
- s_ready combinational from state, m_valid, m_ready only (no path from s_valid).
- Last sample accepted at cycle t -> state WAIT_DONE at t+1, s_ready=0 from t+1.
- fft_done at cycle t in WAIT_DONE with m_valid=0 -> frame_count increments at t+1, state STREAM (s_ready may be 1) at t+1.
- Minimum gap between frames: 1 cycle after fft_done.
- busy registered-state decode, no glitch paths.

## Test plan
- Reset then enable=1, s_valid=1, m_ready=1, ramp data 0..511: m_valid 1 cycle after first accept; m_first on data 0 with win_addr 0; m_last on data 511 with win_addr 511; s_ready=0 after 512 accepts.
- Same, fft_done pulse 5 cycles after m_last: frame_count 0->1, second frame starts next cycle with win_addr 0 and m_first=1; err=0.
- Random m_ready (50%) over 3 frames: no sample lost/duplicated, m_data order matches input, win_addr = sample index mod 512, held stable while m_valid & !m_ready.
- enable dropped after sample 100 of frame: all 512 samples still delivered, after fft_done state IDLE, s_ready=0, busy=0, frame_count=1.
- fft_done pulsed during STREAM at sample 200: err=1 sticky, frame continues normally, frame_count unchanged until real fft_done.
- reset asserted at sample 300: same cycle m_valid=0, win_addr=0, frame_count=0, err=0; after release and enable, next frame begins at win_addr 0 with m_first=1.
